load_store_unit: RTL and testbench

//  MIPS load/store front-end between the MEM pipeline stage and data_mem. Accepts one
//  LB/LBU/LH/LHU/LW/SB/SH/SW request at a time through a valid/ready handshake.

---
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MIPS load/store front-end: word-aligns data_mem accesses, does read-modify-write
// for sub-word stores and returns extended load data or an error code.

module lsu_byte_merge (
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  input  logic       sel,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int MEM_ADDR_W  = 8,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [1:0]  resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;
  localparam logic [1:0] E_OK = 2'b00, E_ALIGN = 2'b01, E_RANGE = 2'b10, E_SIZE = 2'b11;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic [31:0] word_q;
  logic        accept;
  logic [1:0]  req_err;
  logic        out_of_range;
  logic [31:0] shifted, load_ext;

  logic [NUM_LANES-1:0][7:0] old_lanes, wd_lanes, new_lanes, merged;
  logic [NUM_LANES-1:0]      lane_sel;

  assign accept = req_valid && req_ready;

  assign out_of_range = CHECK_RANGE && ((req_addr >> MEM_ADDR_W) != 32'd0);

  always_comb begin
    req_err = E_OK;
    if (req_size == SZ_X)
      req_err = E_SIZE;
    else if (out_of_range)
      req_err = E_RANGE;
    else if ((req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00))
      req_err = E_ALIGN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_write_en = 1'b0;
    mem_address  = 32'd0;
    mem_data_in  = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (accept) begin
          if (req_err != E_OK)                      state_d = RESP;
          else if (!req_write || req_size != SZ_W)  state_d = RD;
          else                                      state_d = WR;
        end
      end
      RD: begin
        mem_address = {req_q.addr[31:2], 2'b00};
        state_d     = req_q.write ? WR : RESP;
      end
      WR: begin
        mem_address  = {req_q.addr[31:2], 2'b00};
        mem_write_en = 1'b1;
        mem_data_in  = merged;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Half loads are 2-byte aligned, so a byte-granular shift serves both sizes.
  assign shifted = mem_data_out >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    load_ext = mem_data_out;
    if (req_q.size == SZ_B)
      load_ext = req_q.uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (req_q.size == SZ_H)
      load_ext = req_q.uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  assign old_lanes = word_q;
  assign wd_lanes  = req_q.wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    always_comb begin
      case (req_q.size)
        SZ_W:    begin new_lanes[i] = wd_lanes[i];       lane_sel[i] = 1'b1; end
        SZ_H:    begin new_lanes[i] = wd_lanes[i % 2];   lane_sel[i] = (req_q.addr[1] == LANE[1]); end
        default: begin new_lanes[i] = wd_lanes[0];       lane_sel[i] = (req_q.addr[1:0] == LANE); end
      endcase
    end
    lsu_byte_merge u_merge (
      .old_byte (old_lanes[i]),
      .new_byte (new_lanes[i]),
      .sel      (lane_sel[i]),
      .merged   (merged[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      word_q     <= 32'd0;
      resp_err   <= E_OK;
      resp_rdata <= 32'd0;
    end else begin
      if (accept)
        req_q <= '{write: req_write, size: req_size, uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata};
      if (state_q == RD)
        word_q <= mem_data_out;
      // Response registers update only on entry to RESP and hold otherwise.
      if (accept && req_err != E_OK) begin
        resp_err   <= req_err;
        resp_rdata <= 32'd0;
      end else if (state_q == RD && !req_q.write) begin
        resp_err   <= E_OK;
        resp_rdata <= load_ext;
      end else if (state_q == WR) begin
        resp_err   <= E_OK;
        resp_rdata <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-wide data_mem.

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [1:0]  resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_en;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic        tb_wr_en = 1'b0;
  logic [5:0]  tb_wr_idx = '0;
  logic [31:0] tb_wr_data = '0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_W(8), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  assign mem_data_out = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (tb_wr_en)          mem[tb_wr_idx] <= tb_wr_data;
    else if (mem_write_en) mem[mem_address[7:2]] <= mem_data_in;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
    int          wcnt;
    logic [31:0] wdat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_idx = addr[7:2]; tb_wr_data = data;
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, wcnt;
    logic [31:0] wd, wa;
    bit done;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    // Junk on the request bus must not disturb the captured request.
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_size = 2'b11;
    lat = 1; wcnt = 0; wd = '0; wa = '0; done = 1'b0;
    while (!done && lat <= 8) begin
      if (mem_write_en) begin wcnt++; wd = mem_data_in; wa = mem_address; end
      if (resp_valid) done = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    check($sformatf("v%0d_err", idx), {30'd0, resp_err}, {30'd0, v.err});
    check($sformatf("v%0d_rdata", idx), resp_rdata, v.rdata);
    check($sformatf("v%0d_wr_pulses", idx), wcnt, v.wcnt);
    if (v.wcnt > 0) begin
      check($sformatf("v%0d_wr_data", idx), wd, v.wdat);
      check($sformatf("v%0d_wr_addr", idx), wa, {v.addr[31:2], 2'b00});
    end
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", idx), {31'd0, resp_valid}, 32'd0);
    check($sformatf("v%0d_rdata_hold", idx), resp_rdata, v.rdata);
  endtask

  initial begin
    int k, r, cyc, quiet;
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_exp  [4];

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 2'b00, 32'h0,        2, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        2'b00, 32'hDEADBEEF, 2, 0, 32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        2'b00, 32'hFFFFFFEF, 2, 0, 32'h0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h21,  32'h000000AA, 2'b00, 32'h0,        3, 1, 32'h1122AA44};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        2'b00, 32'hFFFFFFAA, 2, 0, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h21,  32'h0,        2'b00, 32'h000000AA, 2, 0, 32'h0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h22,  32'h00008001, 2'b00, 32'h0,        3, 1, 32'h8001AA44};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        2'b00, 32'hFFFF8001, 2, 0, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        2'b00, 32'h00008001, 2, 0, 32'h0};
    vecs[9]  = '{1'b1, 2'b00, 1'b0, 32'h23,  32'h00000123, 2'b00, 32'h0,        3, 1, 32'h2301AA44};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        2'b00, 32'h2301AA44, 2, 0, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h20,  32'h0,        2'b00, 32'hFFFFAA44, 2, 0, 32'h0};
    vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h13,  32'h0,        2'b01, 32'h0,        1, 0, 32'h0};
    vecs[13] = '{1'b1, 2'b01, 1'b0, 32'h05,  32'h1234,     2'b01, 32'h0,        1, 0, 32'h0};
    vecs[14] = '{1'b0, 2'b11, 1'b0, 32'h13,  32'h0,        2'b11, 32'h0,        1, 0, 32'h0};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        2'b10, 32'h0,        1, 0, 32'h0};
    vecs[16] = '{1'b1, 2'b11, 1'b0, 32'h101, 32'h77,       2'b11, 32'h0,        1, 0, 32'h0};
    vecs[17] = '{1'b0, 2'b01, 1'b0, 32'h101, 32'h0,        2'b10, 32'h0,        1, 0, 32'h0};
    vecs[18] = '{1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        2'b00, 32'h00000023, 2, 0, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, req_ready},    32'd0);
    check("rst_rvalid", {31'd0, resp_valid},   32'd0);
    check("rst_err",    {30'd0, resp_err},     32'd0);
    check("rst_rdata",  resp_rdata,            32'd0);
    check("rst_maddr",  mem_address,           32'd0);
    check("rst_mdin",   mem_data_in,           32'd0);
    check("rst_wen",    {31'd0, mem_write_en}, 32'd0);
    rst = 1'b0;

    poke(32'h20, 32'h11223344);
    poke(32'h30, 32'h55667788);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while the sub-word store is in its write cycle.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h30; req_wdata = 32'h11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstwr_wen_before", {31'd0, mem_write_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_wen_drop",  {31'd0, mem_write_en}, 32'd0);
    check("rstwr_maddr",     mem_address,           32'd0);
    check("rstwr_ready_rst", {31'd0, req_ready},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstwr_mem", mem[12], 32'h55667788);
    check("rstwr_rdata_clr", resp_rdata, 32'd0);
    check("rstwr_ready", {31'd0, req_ready}, 32'd1);
    quiet = 0;
    repeat (4) begin @(negedge clk); if (resp_valid) quiet++; end
    check("rstwr_no_resp", quiet, 0);

    // Four back-to-back word loads with req_valid held high.
    b2b_addr = '{32'h10, 32'h20, 32'h30, 32'h14};
    b2b_exp  = '{32'hDEADBEEF, 32'h2301AA44, 32'h55667788, 32'h0};
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = b2b_addr[0];
    k = 0; r = 0; cyc = 0;
    while (r < 4 && cyc < 40) begin
      if (resp_valid) begin
        check($sformatf("b2b_rdata%0d", r), resp_rdata, b2b_exp[r]);
        check($sformatf("b2b_ready_resp%0d", r), {31'd0, req_ready}, 32'd0);
        r++;
      end
      if (req_valid && req_ready) begin
        check($sformatf("b2b_accept_cycle%0d", k), cyc, 3 * k);
        k++;
      end
      @(posedge clk);
      #1;
      if (k < 4) req_addr = b2b_addr[k];
      else       req_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b_resp_count", r, 4);
    check("b2b_accept_count", k, 4);
    @(negedge clk);
    check("b2b_no_extra", {31'd0, resp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
